// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/capture sequencer wrapped around a 4-bit combinational ALU.
// Optional `define ALU_ERR_FLAG_EN adds res_err_o and keeps the accumulator on divide/mod by zero.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_sel_i,
  input  logic [3:0]            cmd_a_i,
  input  logic [3:0]            cmd_b_i,
  input  logic                  cmd_use_acc_i,
  output logic [3:0]            alu_a_o,
  output logic [3:0]            alu_b_o,
  output logic [2:0]            alu_sel_o,
  input  logic [4:0]            alu_out_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [4:0]            res_data_o,
  output logic [2:0]            res_sel_o,
  output logic                  busy_o,
`ifdef ALU_ERR_FLAG_EN
  output logic                  res_err_o,
`endif
  output logic [$clog2(DEPTH):0] fifo_count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESULT} state_e;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [3:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_sel_q, alu_sel_d;
  logic          res_valid_q, res_valid_d;
  logic [4:0]    res_data_q, res_data_d;
  logic [2:0]    res_sel_q, res_sel_d;
  logic [4:0]    acc_q, acc_d;
  logic          push, pop, fifo_empty;
`ifdef ALU_ERR_FLAG_EN
  logic          res_err_q, res_err_d, cap_err;
  assign cap_err   = ((alu_sel_q == 3'b011) || (alu_sel_q == 3'b100)) && (alu_b_q == 4'd0);
  assign res_err_o = res_err_q;
`endif

  // Ready is derived from the registered count only, so pop never reaches it combinationally.
  assign fifo_empty   = (count_q == '0);
  assign cmd_ready_o  = (count_q != CW'(DEPTH));
  assign push         = cmd_valid_i && cmd_ready_o;
  assign head         = mem_q[rd_ptr_q];
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != IDLE) || !fifo_empty;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_sel_o    = res_sel_q;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sel_d   = res_sel_q;
    acc_d       = acc_q;
`ifdef ALU_ERR_FLAG_EN
    res_err_d   = res_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        res_data_d  = alu_out_i;
        res_sel_d   = alu_sel_q;
        res_valid_d = 1'b1;
`ifdef ALU_ERR_FLAG_EN
        res_err_d   = cap_err;
        if (!cap_err) acc_d = alu_out_i;
`else
        acc_d       = alu_out_i;
`endif
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The accumulator read here was written at the preceding capture, so chaining needs no bypass.
    if (pop) begin
      alu_a_d   = head.use_acc ? acc_q[3:0] : head.a;
      alu_b_d   = head.b;
      alu_sel_d = head.sel;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{sel: cmd_sel_i, a: cmd_a_i, b: cmd_b_i, use_acc: cmd_use_acc_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sel_q   <= '0;
      acc_q       <= '0;
`ifdef ALU_ERR_FLAG_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sel_q   <= res_sel_d;
      acc_q       <= acc_d;
`ifdef ALU_ERR_FLAG_EN
      res_err_q   <= res_err_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU stub on the alu_* ports.
// Build with +define+ALU_ERR_FLAG_EN to also exercise the error-flag variant.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_sel = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       cmd_use_acc = 1'b0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [4:0] alu_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [4:0] res_data;
  logic [2:0] res_sel;
  logic       busy;
  logic [2:0] fifo_count;
`ifdef ALU_ERR_FLAG_EN
  logic       res_err;
`endif

  typedef struct {
    logic [4:0] data;
    logic [2:0] sel;
    logic [3:0] a;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] model_acc = '0;
  int         n_checks = 0;
  int         n_pass = 0;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_sel_i(cmd_sel), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_use_acc_i(cmd_use_acc),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel), .alu_out_i(alu_out),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_sel_o(res_sel), .busy_o(busy),
`ifdef ALU_ERR_FLAG_EN
    .res_err_o(res_err),
`endif
    .fifo_count_o(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_fn(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'b000:  return {1'b0, a};
      3'b001:  return {1'b0, a} + {1'b0, b};
      3'b010:  return {1'b0, a} - {1'b0, b};
      3'b011:  return (b == 4'd0) ? 5'h1F : {1'b0, a / b};
      3'b100:  return (b == 4'd0) ? 5'h1F : {1'b0, a % b};
      3'b101:  return {1'b0, a & b};
      3'b110:  return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_sel, alu_a, alu_b);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no_finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called right after a negedge; offers one command for one edge and records it if accepted.
  task automatic applyStimulus(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                               input logic ua, output bit accepted);
    exp_t e;
    cmd_sel = s; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    accepted = cmd_ready;
    if (accepted) begin
      e.a    = ua ? model_acc[3:0] : a;
      e.sel  = s;
      e.data = alu_fn(s, e.a, b);
      e.err  = ((s == 3'b011) || (s == 3'b100)) && (b == 4'd0);
`ifdef ALU_ERR_FLAG_EN
      if (!e.err) model_acc = e.data;
`else
      model_acc = e.data;
`endif
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rst_cmd_ready got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("[TB] FAIL rst_res_valid got %b want 0", res_valid); else n_pass++;
    n_checks++; if (res_data !== 5'h00) $display("[TB] FAIL rst_res_data got %h want 00", res_data); else n_pass++;
    n_checks++; if (res_sel !== 3'b000) $display("[TB] FAIL rst_res_sel got %b want 000", res_sel); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_sel} !== 11'd0) $display("[TB] FAIL rst_alu_regs got %h want 000", {alu_a, alu_b, alu_sel}); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL rst_fifo_count got %0d want 0", fifo_count); else n_pass++;
  endtask

  task automatic test_add_sub;
    bit ok;
    exp_t e;
    int t;
    res_ready = 1'b1;
    applyStimulus(3'b001, 4'd5, 4'd6, 1'b0, ok);
    n_checks++; if (!ok) $display("[TB] FAIL add_accept got 0 want 1"); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== (k == 3)) $display("[TB] FAIL add_latency_e%0d got %b want %b", k, res_valid, (k == 3));
      else n_pass++;
    end
    e = sb.pop_front();
    n_checks++; if (res_data !== e.data) $display("[TB] FAIL add_data got %h want %h", res_data, e.data); else n_pass++;
    n_checks++; if (res_sel !== e.sel) $display("[TB] FAIL add_sel got %b want %b", res_sel, e.sel); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL add_busy_after got %b want 0", busy); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("[TB] FAIL add_valid_after got %b want 0", res_valid); else n_pass++;

    applyStimulus(3'b010, 4'd3, 4'd5, 1'b0, ok);
    t = 0;
    while (res_valid !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    n_checks++;
    if (res_valid !== 1'b1 || sb.size() == 0) $display("[TB] FAIL sub_wait got timeout want result");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++; if (res_data !== e.data) $display("[TB] FAIL sub_data got %h want %h", res_data, e.data); else n_pass++;
      n_checks++; if (res_sel !== e.sel) $display("[TB] FAIL sub_sel got %b want %b", res_sel, e.sel); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_chain;
    bit ok;
    exp_t e;
    int t;
    res_ready = 1'b1;
    applyStimulus(3'b001, 4'd7, 4'd8, 1'b0, ok);
    applyStimulus(3'b001, 4'd2, 4'd1, 1'b1, ok);
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (res_valid !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      n_checks++;
      if (res_valid !== 1'b1 || sb.size() == 0) $display("[TB] FAIL chain_wait%0d got timeout want result", i);
      else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++; if (res_data !== e.data) $display("[TB] FAIL chain_data%0d got %h want %h", i, res_data, e.data); else n_pass++;
        n_checks++; if (alu_a !== e.a) $display("[TB] FAIL chain_alu_a%0d got %h want %h", i, alu_a, e.a); else n_pass++;
        @(negedge clk);
      end
    end
  endtask

`ifdef ALU_ERR_FLAG_EN
  task automatic test_err_flag;
    bit ok;
    exp_t e;
    int t;
    res_ready = 1'b1;
    applyStimulus(3'b000, 4'd4, 4'd0, 1'b0, ok);
    applyStimulus(3'b011, 4'd9, 4'd0, 1'b0, ok);
    applyStimulus(3'b001, 4'd0, 4'd1, 1'b1, ok);
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (res_valid !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      n_checks++;
      if (res_valid !== 1'b1 || sb.size() == 0) $display("[TB] FAIL err_wait%0d got timeout want result", i);
      else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++; if (res_data !== e.data) $display("[TB] FAIL err_data%0d got %h want %h", i, res_data, e.data); else n_pass++;
        n_checks++; if (res_err !== e.err) $display("[TB] FAIL err_flag%0d got %b want %b", i, res_err, e.err); else n_pass++;
        @(negedge clk);
      end
    end
  endtask
`endif

  task automatic test_backpressure;
    logic [2:0] sel_tab [6] = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b111, 3'b011};
    logic [3:0] a_tab   [6] = '{4'd1, 4'd9, 4'd12, 4'd3, 4'd15, 4'd8};
    logic [3:0] b_tab   [6] = '{4'd2, 4'd4, 4'd10, 4'd5, 4'd6, 4'd2};
    bit ok;
    int n_acc = 0;
    exp_t e;
    int t;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(sel_tab[i], a_tab[i], b_tab[i], 1'b0, ok);
      if (ok) n_acc++;
    end
    n_checks++; if (n_acc != 5) $display("[TB] FAIL bp_accepted got %0d want 5", n_acc); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL bp_cmd_ready got %b want 0", cmd_ready); else n_pass++;
    n_checks++; if (fifo_count !== 3'd4) $display("[TB] FAIL bp_fifo_count got %0d want 4", fifo_count); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      t = 0;
      while (res_valid !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      n_checks++;
      if (res_valid !== 1'b1 || sb.size() == 0) $display("[TB] FAIL bp_wait%0d got timeout want result", i);
      else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++; if (res_data !== e.data) $display("[TB] FAIL bp_data%0d got %h want %h", i, res_data, e.data); else n_pass++;
        n_checks++; if (res_sel !== e.sel) $display("[TB] FAIL bp_sel%0d got %b want %b", i, res_sel, e.sel); else n_pass++;
        res_ready = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    exp_t e;
    int t;
    int stale = 0;
    res_ready = 1'b0;
    applyStimulus(3'b001, 4'd1, 4'd1, 1'b0, ok);
    applyStimulus(3'b001, 4'd2, 4'd2, 1'b0, ok);
    applyStimulus(3'b001, 4'd3, 4'd3, 1'b0, ok);
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b1) $display("[TB] FAIL rm_pre_valid got %b want 1", res_valid); else n_pass++;
    n_checks++; if (fifo_count !== 3'd2) $display("[TB] FAIL rm_pre_count got %0d want 2", fifo_count); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    model_acc = '0;
    n_checks++; if (res_valid !== 1'b0) $display("[TB] FAIL rm_res_valid got %b want 0", res_valid); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL rm_fifo_count got %0d want 0", fifo_count); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rm_cmd_ready got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rm_busy got %b want 0", busy); else n_pass++;
    res_ready = 1'b1;
    applyStimulus(3'b001, 4'd9, 4'd3, 1'b1, ok);
    t = 0;
    while (res_valid !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    n_checks++;
    if (res_valid !== 1'b1 || sb.size() == 0) $display("[TB] FAIL rm_wait got timeout want result");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++; if (res_data !== e.data) $display("[TB] FAIL rm_acc_data got %h want %h", res_data, e.data); else n_pass++;
      n_checks++; if (alu_a !== e.a) $display("[TB] FAIL rm_acc_alu_a got %h want %h", alu_a, e.a); else n_pass++;
      @(negedge clk);
    end
    repeat (12) begin
      @(negedge clk);
      if (res_valid === 1'b1) stale++;
    end
    n_checks++; if (stale != 0) $display("[TB] FAIL rm_stale got %0d want 0", stale); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_chain();
`ifdef ALU_ERR_FLAG_EN
    test_err_flag();
`endif
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
